// File: rtl/microcode_sequencer.sv
// Micro-program sequencer: walks the microcode ROM, resolves JMP/BRZ/HALT locally
// and offers every other word to the datapath over a valid/ready handshake.
`timescale 1ns/1ps
module microcode_sequencer #(
  parameter int ROM_addressBits = 6,
  parameter int RF_addressBits  = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        zero_flag,
  output logic                        ROM_readEnable,
  output logic [ROM_addressBits-1:0]  ROM_address,
  input  logic [3+2*RF_addressBits:0] ROM_data,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [3:0]                  instr_opcode,
  output logic [RF_addressBits-1:0]   instr_a,
  output logic [RF_addressBits-1:0]   instr_b,
  output logic [ROM_addressBits-1:0]  pc,
  output logic                        busy,
  output logic                        done
);
  localparam int N = RF_addressBits;
  localparam logic [3:0] OP_JMP  = 4'hF;
  localparam logic [3:0] OP_BRZ  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hD;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [ROM_addressBits-1:0] r_pc;
  logic [ROM_addressBits-1:0] w_pc_next;
  logic [ROM_addressBits-1:0] w_pc_inc;
  logic [ROM_addressBits-1:0] w_target;
  logic [3:0]                 w_opcode;
  logic                       w_is_ctrl;

  assign w_opcode  = ROM_data[3+2*N:2*N];
  assign w_target  = ROM_addressBits'(ROM_data[2*N-1:0]);
  assign w_pc_inc  = r_pc + ROM_addressBits'(1);
  assign w_is_ctrl = (w_opcode == OP_JMP) || (w_opcode == OP_BRZ) || (w_opcode == OP_HALT);

  // State and micro-PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Next-state and next-pc decode; abort wins over every other transition
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    if (abort) begin
      w_state_next = S_IDLE;
      w_pc_next    = r_pc;
    end else begin
      case (r_state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            w_pc_next    = '0;
            w_state_next = S_FETCH;
          end else begin
            w_state_next = r_state;
          end
        end
        S_FETCH: w_state_next = S_EXEC;
        S_EXEC: begin
          case (w_opcode)
            OP_JMP: begin
              w_pc_next    = w_target;
              w_state_next = S_FETCH;
            end
            OP_BRZ: begin
              w_pc_next    = zero_flag ? w_target : w_pc_inc;
              w_state_next = S_FETCH;
            end
            OP_HALT: w_state_next = S_HALTED;
            default: begin
              if (instr_ready) begin
                w_pc_next    = w_pc_inc;
                w_state_next = S_FETCH;
              end else begin
                w_state_next = S_EXEC;
              end
            end
          endcase
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // ROM_data is held by the ROM during EXEC, so the offer stays stable without a copy
  assign ROM_readEnable = (r_state == S_FETCH);
  assign ROM_address    = r_pc;
  assign pc             = r_pc;
  assign busy           = (r_state == S_FETCH) || (r_state == S_EXEC);
  assign done           = (r_state == S_HALTED);
  assign instr_valid    = (r_state == S_EXEC) && !w_is_ctrl;
  assign instr_opcode   = w_opcode;
  assign instr_a        = ROM_data[2*N-1:N];
  assign instr_b        = ROM_data[N-1:0];
endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed scenarios plus random forward-only programs
// checked against an instruction-level interpreter of the micro-program.
`timescale 1ns/1ps
module tb_microcode_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, start, abort, zero_flag, instr_ready;
  logic       rom_re, instr_valid, busy, done;
  logic [5:0] rom_addr, pc;
  logic [9:0] rom_data = 10'd0;
  logic [3:0] op;
  logic [2:0] ia, ib;
  logic [9:0] mem [0:63];
  int checks = 0;
  int failures = 0;

  microcode_sequencer #(.ROM_addressBits(6), .RF_addressBits(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .zero_flag(zero_flag),
    .ROM_readEnable(rom_re), .ROM_address(rom_addr), .ROM_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(op),
    .instr_a(ia), .instr_b(ib), .pc(pc), .busy(busy), .done(done));

  always #5 clk = ~clk;

  // synchronous ROM: data appears the cycle after the strobe and then holds
  always @(posedge clk) if (rom_re) rom_data <= mem[rom_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 10'd0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; zero_flag = 1'b0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic load_linear();
    clear_mem();
    mem[0] = 10'b0001_001_010;
    mem[1] = 10'b0010_011_100;
    mem[2] = 10'b1101_000_000;
  endtask

  task automatic run_linear(input string tag);
    logic [9:0] exp_f;
    logic       exp_v;
    instr_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      exp_v = (c == 2) || (c == 4);
      checks++;
      if (instr_valid !== exp_v) begin
        failures++; $display("FAIL %s_valid c%0d: got %b expected %b", tag, c, instr_valid, exp_v);
      end
      if (exp_v) begin
        exp_f = (c == 2) ? 10'b0001_001_010 : 10'b0010_011_100;
        checks++;
        if ({op, ia, ib} !== exp_f) begin
          failures++; $display("FAIL %s_fields c%0d: got %b expected %b", tag, c, {op, ia, ib}, exp_f);
        end
      end
      checks++;
      if (done !== (c >= 7)) begin
        failures++; $display("FAIL %s_done c%0d: got %b expected %b", tag, c, done, c >= 7);
      end
      tick();
    end
    checks++;
    if (pc !== 6'd2) begin failures++; $display("FAIL %s_pc: got %0d expected 2", tag, pc); end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({rom_re, rom_addr, pc, instr_valid, busy, done} !== 16'd0) begin
      failures++; $display("FAIL reset_values: got %b expected all zero", {rom_re, rom_addr, pc, instr_valid, busy, done});
    end
  endtask

  task automatic test_linear();
    reset_dut(); load_linear();
    run_linear("linear");
  endtask

  task automatic test_backpressure();
    reset_dut(); load_linear();
    instr_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      instr_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      if (c >= 2 && c <= 5) begin
        checks++;
        if ({instr_valid, op, ia, ib, pc} !== {1'b1, 10'b0001_001_010, 6'd0}) begin
          failures++; $display("FAIL bp_hold c%0d: got v=%b f=%b pc=%0d expected v=1 f=0001001010 pc=0", c, instr_valid, {op, ia, ib}, pc);
        end
      end
      if (c == 6) begin
        checks++;
        if ({instr_valid, busy, pc} !== {1'b0, 1'b1, 6'd1}) begin
          failures++; $display("FAIL bp_after: got v=%b busy=%b pc=%0d expected v=0 busy=1 pc=1", instr_valid, busy, pc);
        end
      end
      tick();
    end
  endtask

  task automatic test_control_flow(input logic zf, input logic [5:0] tpc);
    logic [5:0] exp_pc;
    reset_dut(); clear_mem();
    mem[0] = 10'b1111_000_101; mem[5] = 10'b1110_001_000;
    mem[6] = 10'b1101_000_000; mem[8] = 10'b1101_000_000;
    zero_flag = zf; instr_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      exp_pc = (c <= 2) ? 6'd0 : (c <= 4) ? 6'd5 : tpc;
      checks++;
      if ({pc, instr_valid, done} !== {exp_pc, 1'b0, c == 7}) begin
        failures++; $display("FAIL ctrl_zf%0d c%0d: got pc=%0d v=%b done=%b expected pc=%0d v=0 done=%b", zf, c, pc, instr_valid, done, exp_pc, c == 7);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    reset_dut(); clear_mem();
    mem[0] = 10'b1111_111_111; mem[63] = 10'b0011_101_110;
    instr_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    checks++;
    if ({rom_re, rom_addr} !== {1'b1, 6'd63}) begin
      failures++; $display("FAIL wrap_fetch63: got re=%b addr=%0d expected re=1 addr=63", rom_re, rom_addr);
    end
    tick();
    checks++;
    if ({instr_valid, op, ia, ib, pc} !== {1'b1, 10'b0011_101_110, 6'd63}) begin
      failures++; $display("FAIL wrap_offer: got v=%b f=%b pc=%0d expected v=1 f=0011101110 pc=63", instr_valid, {op, ia, ib}, pc);
    end
    tick();
    checks++;
    if ({rom_re, rom_addr, pc} !== {1'b1, 6'd0, 6'd0}) begin
      failures++; $display("FAIL wrap_pc0: got re=%b addr=%0d pc=%0d expected re=1 addr=0 pc=0", rom_re, rom_addr, pc);
    end
    tick();
    checks++;
    if ({instr_valid, op} !== {1'b0, 4'hF}) begin
      failures++; $display("FAIL wrap_refetch: got v=%b op=%h expected v=0 op=f", instr_valid, op);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_abort();
    reset_dut(); load_linear();
    instr_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({instr_valid, pc} !== {1'b1, 6'd1}) begin
      failures++; $display("FAIL abort_pre: got v=%b pc=%0d expected v=1 pc=1", instr_valid, pc);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if ({busy, instr_valid, done, rom_re, pc} !== {4'b0000, 6'd1}) begin
      failures++; $display("FAIL abort_idle: got busy=%b v=%b done=%b re=%b pc=%0d expected 0 0 0 0 pc=1", busy, instr_valid, done, rom_re, pc);
    end
    tick(); tick();
    checks++;
    if ({busy, pc} !== {1'b0, 6'd1}) begin
      failures++; $display("FAIL abort_stay: got busy=%b pc=%0d expected busy=0 pc=1", busy, pc);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({rom_re, rom_addr, pc} !== {1'b1, 6'd0, 6'd0}) begin
      failures++; $display("FAIL abort_restart: got re=%b addr=%0d pc=%0d expected re=1 addr=0 pc=0", rom_re, rom_addr, pc);
    end
    tick();
    checks++;
    if ({instr_valid, op, ia, ib} !== {1'b1, 10'b0001_001_010}) begin
      failures++; $display("FAIL abort_first: got v=%b f=%b expected v=1 f=0001001010", instr_valid, {op, ia, ib});
    end
  endtask

  task automatic test_async_reset();
    reset_dut(); load_linear();
    instr_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rom_re, rom_addr, pc, instr_valid, busy, done} !== 16'd0) begin
      failures++; $display("FAIL async_reset: got %b expected all zero", {rom_re, rom_addr, pc, instr_valid, busy, done});
    end
    @(posedge clk); #2 rst_n = 1'b1;
    tick();
    run_linear("post_reset");
  endtask

  task automatic test_random();
    logic [15:0] q[$];
    logic [9:0]  w;
    logic [9:0]  hold_f;
    logic [5:0]  p, tgt, final_pc;
    logic        zf, hold, finished;
    int          len, words, stalls, c, r;
    reset_dut();
    for (int it = 0; it < 25; it++) begin
      clear_mem();
      len = $urandom_range(4, 20);
      zf = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        tgt = 6'($urandom_range(i + 1, len));
        if (r < 6)       mem[i] = {4'($urandom_range(0, 12)), 6'($urandom_range(0, 63))};
        else if (r < 8)  mem[i] = {4'hF, tgt};
        else             mem[i] = {4'hE, tgt};
      end
      mem[len] = {4'hD, 6'($urandom_range(0, 63))};
      // interpreter: expected datapath stream and word count
      q.delete(); words = 0; p = 6'd0;
      forever begin
        w = mem[p]; words++;
        if (w[9:6] == 4'hF) p = w[5:0];
        else if (w[9:6] == 4'hE) p = zf ? w[5:0] : p + 6'd1;
        else if (w[9:6] == 4'hD) break;
        else begin q.push_back({p, w}); p = p + 6'd1; end
      end
      final_pc = p;
      zero_flag = zf; start = 1'b1; tick(); start = 1'b0;
      stalls = 0; c = 1; finished = 1'b0; hold = 1'b0; hold_f = 10'd0;
      while (!finished && c < 300) begin
        instr_ready = ($urandom_range(0, 3) != 0);
        start = busy && ($urandom_range(0, 7) == 0);
        if (done) begin
          finished = 1'b1;
          checks++;
          if (c != 2 * words + stalls + 1 || q.size() != 0 || pc !== final_pc) begin
            failures++; $display("FAIL rand_end it%0d: got cycle=%0d left=%0d pc=%0d expected cycle=%0d left=0 pc=%0d", it, c, q.size(), pc, 2 * words + stalls + 1, final_pc);
          end
        end else begin
          if (hold) begin
            checks++;
            if ({instr_valid, op, ia, ib} !== {1'b1, hold_f}) begin
              failures++; $display("FAIL rand_hold it%0d c%0d: got v=%b f=%b expected v=1 f=%b", it, c, instr_valid, {op, ia, ib}, hold_f);
            end
          end
          if (instr_valid === 1'b1) begin
            if (instr_ready) begin
              checks++;
              if (q.size() == 0 || {pc, op, ia, ib} !== q[0]) begin
                failures++; $display("FAIL rand_xfer it%0d c%0d: got %h expected %h", it, c, {pc, op, ia, ib}, (q.size() == 0) ? 16'hxxxx : q[0]);
              end
              if (q.size() != 0) void'(q.pop_front());
            end else begin
              stalls++;
            end
            hold = !instr_ready; hold_f = {op, ia, ib};
          end else begin
            hold = 1'b0;
          end
          tick(); c++;
        end
      end
      start = 1'b0;
      if (!finished) begin
        checks++; failures++;
        $display("FAIL rand_timeout it%0d: done not seen within 300 cycles", it);
      end
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_backpressure();
    test_control_flow(1'b1, 6'd8);
    test_control_flow(1'b0, 6'd6);
    test_wrap();
    test_abort();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

Microprogram sequencer that owns the synchronous microcode ROM and walks it: it keeps the micro-program counter and drives the ROM read port. It resolves control-flow microinstructions (jump, branch-on-zero, halt) internally. All other words are handed to the datapath over a valid/ready handshake. It sits between the top-level start/done control and the ROM/datapath pair.

## Interface
- ROM_addressBits, default 6: micro-PC and ROM address width.
- RF_addressBits, default 3: width of each operand field; the ROM word is 4+2*RF_addressBits bits.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- start  in  1  level-sampled in IDLE/HALTED; begins execution at address 0.
- abort  in  1  synchronous; forces IDLE from any state.
- zero_flag  in  1  datapath zero flag, sampled in EXEC for BRZ.
- ROM_readEnable  out  1  ROM read strobe.
- ROM_address  out  ROM_addressBits  equals pc.
- ROM_data  in  4+2*RF_addressBits  ROM word, valid the cycle after a read strobe.
- instr_valid  out  1  datapath instruction offered.
- instr_ready  in  1  datapath accepts the instruction.
- instr_opcode  out  4  ROM_data[3+2N:2N], where N=RF_addressBits.
- instr_a  out  N  ROM_data[2N-1:N].
- instr_b  out  N  ROM_data[N-1:0].
- pc  out  ROM_addressBits  current micro-PC.
- busy  out  1  high in FETCH/EXEC.
- done  out  1  high in HALTED.

## Operation
- Word format is {opcode[3:0], A[N-1:0], B[N-1:0]}.
- Target = {A,B}, truncated or zero-extended to ROM_addressBits.
- Opcodes decoded internally:
  - 4'hF JMP: pc <= target.
  - 4'hE BRZ: pc <= zero_flag ? target : pc+1.
  - 4'hD HALT: enter HALTED.
- All other opcodes are datapath instructions.
- States IDLE, FETCH, EXEC, HALTED; reset state IDLE, pc=0.
- IDLE: on start=1, pc <= 0, go FETCH.
- FETCH: ROM_readEnable=1 and ROM_address=pc; go EXEC unconditionally.
- EXEC: ROM_readEnable=0, so ROM_data holds stable. Decode ROM_data:
  - JMP/BRZ: update pc, go FETCH. instr_valid stays 0.
  - HALT: pc unchanged, go HALTED.
  - Datapath op: instr_valid=1, with instr_* driven combinationally from ROM_data. Hold until instr_ready=1. On the handshake cycle pc <= pc+1, go FETCH.
- instr_valid, once raised, is not withdrawn until handshake or abort.
- HALTED: done=1. On start=1, pc <= 0, go FETCH. The done/start overlap cycle is legal.
- pc+1 wraps modulo 2^ROM_addressBits: max address goes to 0, no flag.
- abort has priority over every transition. Next state is IDLE, pc unchanged, instr_valid drops next cycle, no pc increment even if instr_ready is high in the same cycle.
- start while busy is ignored.
- Asynchronous reset mid-operation: immediately IDLE, all outputs to reset values; the in-flight instruction is lost.

## Timing
- Reset values:
  - ROM_readEnable=0, ROM_address=0, pc=0.
  - instr_valid=0, busy=0, done=0.
  - instr_* follow ROM_data; don't-care while instr_valid=0.
- start sampled at edge k: FETCH in cycle k+1, EXEC in cycle k+2, so instr_valid is first possible in cycle k+2.
- Datapath op with instr_ready already high: 2 cycles per instruction (FETCH+EXEC).
- Each cycle instr_ready is low adds one cycle.
- JMP/BRZ: 2 cycles, no datapath slot.
- HALT: done rises the cycle after EXEC.
- No combinational path from instr_ready to instr_valid.
- zero_flag is sampled only on the EXEC cycle of a BRZ.

## Test plan
All with N=3, ROM_addressBits=6.
- Linear: ROM[0]=0001_001_010, ROM[1]=0010_011_100, ROM[2]=1101_000_000, instr_ready tied 1, start pulse. Expect instr_valid in cycles 2 and 4 with (1,1,2) then (2,3,4), done=1 from cycle 7, pc=2.
- Backpressure: same program, instr_ready low for 3 cycles on the first instruction. Expect instr_valid and fields held constant for 4 cycles, pc stays 0 until handshake, then pc=1.
- Control flow: ROM[0]=1111_000_101 (JMP 5), ROM[5]=1110_001_000 (BRZ 8), ROM[6]=HALT, ROM[8]=HALT.
  - zero_flag=1: pc sequence 0,5,8, done=1, instr_valid never high.
  - zero_flag=0: pc ends at 6.
- Wrap: preload pc=63 via JMP 63, ROM[63]=datapath op. After handshake, pc=0 and fetch proceeds from ROM[0].
- Abort: assert abort in the EXEC cycle with instr_valid=1 and instr_ready=1. Expect IDLE next cycle, pc unchanged, no increment, busy=0. A later start restarts at 0.
- Reset: drop rst_n asynchronously mid-FETCH. Outputs go to reset values without waiting for a clock edge; after release, start behaves as in the linear scenario.
